// File: rtl/mdv_rx_pkg.sv
// Shared constants for the microdrive receive/control interface.
// Register map, STATUS/CONTROL bit positions and the control register layout.
package mdv_rx_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_DATA    = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_IRQ_CLR = 2'd3;

    localparam int ST_RX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_GAP       = 3;
    localparam int ST_GAP_PEND  = 4;
    localparam int ST_FIFO_FULL = 6;

    localparam int CT_SEL_DATA = 0;
    localparam int CT_SEL_CLK  = 1;
    localparam int CT_IRQ_EN   = 2;

    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic irq_en;
        logic sel_clk;
        logic sel_data;
    } ctrl_t;

endpackage

// File: rtl/mdv_rx_sync.sv
// Multi-flop synchroniser with a history flop for rising-edge detection.
// STAGES must be at least 2.
module mdv_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_hist;

endmodule

// File: rtl/mdv_rx_if.sv
// CPU-side microdrive receive/control interface: status/data registers, gap irq
// and serial drive-select shift register. Define MDV_RX_FIFO_EN for a 4-entry rx FIFO.
module mdv_rx_if
    import mdv_rx_pkg::*;
#(
    parameter int NUM_DRIVES  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            cpu_addr,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    input  logic                  mdv_gap,
    input  logic                  mdv_rx_ready,
    input  logic [7:0]            mdv_dout,
    output logic [NUM_DRIVES-1:0] mdv_sel,
    output logic                  irq
);

    logic w_gap_level, w_gap_rise, w_rx_level, w_rx_rise;
    logic w_rd_data, w_rd_stat, w_wr_ctrl, w_wr_clr;
    logic w_rx_full, w_fifo_full;
    logic [7:0] w_data;
    logic [7:0] w_dout;
    logic w_unused;

    ctrl_t                 r_ctrl;
    logic [NUM_DRIVES-1:0] r_sel;
    logic                  r_gap_pend;
    logic                  r_irq;
    logic                  r_ovr;

    mdv_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_gap (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (mdv_gap),
        .o_level (w_gap_level),
        .o_rise  (w_gap_rise)
    );

    mdv_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_rx (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (mdv_rx_ready),
        .o_level (w_rx_level),
        .o_rise  (w_rx_rise)
    );

    assign w_rd_data = cpu_rd && (cpu_addr == REG_DATA);
    assign w_rd_stat = cpu_rd && (cpu_addr == REG_STATUS);
    assign w_wr_ctrl = cpu_wr && (cpu_addr == REG_CONTROL);
    assign w_wr_clr  = cpu_wr && (cpu_addr == REG_IRQ_CLR);
    assign w_unused  = ^{cpu_din[7:3], w_rx_level};

`ifdef MDV_RX_FIFO_EN
    logic [7:0] r_mem [FIFO_DEPTH];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_cnt;
    logic       w_pop, w_push_ok;

    assign w_rx_full   = (r_cnt != 3'd0);
    assign w_fifo_full = (r_cnt == 3'(FIFO_DEPTH));
    assign w_pop       = w_rd_data && w_rx_full;
    // A full FIFO still accepts a byte when the same cycle pops one.
    assign w_push_ok   = w_rx_rise && (!w_fifo_full || w_pop);
    assign w_data      = w_rx_full ? r_mem[r_rp] : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_cnt <= 3'd0;
            r_ovr <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wp] <= mdv_dout;
                r_wp        <= r_wp + 2'd1;
            end
            if (w_pop) r_rp <= r_rp + 2'd1;
            case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_rx_rise && w_fifo_full && !w_pop) r_ovr <= 1'b1;
            else if (w_rd_stat)                     r_ovr <= 1'b0;
        end
    end
`else
    logic [7:0] r_latch;
    logic       r_full;

    assign w_rx_full   = r_full;
    assign w_fifo_full = 1'b0;
    assign w_data      = r_latch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_latch <= 8'h00;
            r_full  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_rx_rise) begin
                r_latch <= mdv_dout;
                r_full  <= 1'b1;
            end else if (w_rd_data) begin
                r_full  <= 1'b0;
            end
            // A DATA read in the same cycle consumes the old byte, so no overrun.
            if (w_rx_rise && r_full && !w_rd_data) r_ovr <= 1'b1;
            else if (w_rd_stat)                    r_ovr <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl     <= '0;
            r_sel      <= '0;
            r_gap_pend <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= cpu_din[2:0];
                if (!r_ctrl.sel_clk && cpu_din[CT_SEL_CLK])
                    r_sel <= {r_sel[NUM_DRIVES-2:0], cpu_din[CT_SEL_DATA]};
            end
            if (w_gap_rise)                  r_gap_pend <= 1'b1;
            else if (w_wr_clr && cpu_din[0]) r_gap_pend <= 1'b0;
            r_irq <= r_gap_pend & r_ctrl.irq_en;
        end
    end

    always_comb begin
        w_dout = 8'h00;
        case (cpu_addr)
            REG_STATUS: begin
                w_dout[ST_RX_FULL]   = w_rx_full;
                w_dout[ST_TX_EMPTY]  = 1'b0;
                w_dout[ST_OVERRUN]   = r_ovr;
                w_dout[ST_GAP]       = w_gap_level;
                w_dout[ST_GAP_PEND]  = r_gap_pend;
                w_dout[ST_FIFO_FULL] = w_fifo_full;
            end
            REG_DATA:    w_dout = w_data;
            REG_CONTROL: w_dout[2:0] = r_ctrl;
            default:     w_dout = 8'h00;
        endcase
    end

    assign cpu_dout = w_dout;
    assign mdv_sel  = r_sel;
    assign irq      = r_irq;

endmodule

// File: tb/tb_mdv_rx_if.sv
// Directed bench for mdv_rx_if with a byte scoreboard for the receive path.
module tb_mdv_rx_if;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] cpu_addr = 2'd0;
    logic       cpu_wr = 1'b0;
    logic       cpu_rd = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic [7:0] cpu_dout;
    logic       mdv_gap = 1'b0;
    logic       mdv_rx_ready = 1'b0;
    logic [7:0] mdv_dout = 8'h00;
    logic [7:0] mdv_sel;
    logic       irq;

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0] q[$];
    logic [7:0] m_latch = 8'h00;
    logic       m_ovr = 1'b0;
    logic [7:0] d;

`ifdef MDV_RX_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    mdv_rx_if #(.NUM_DRIVES(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_addr     (cpu_addr),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_din      (cpu_din),
        .cpu_dout     (cpu_dout),
        .mdv_gap      (mdv_gap),
        .mdv_rx_ready (mdv_rx_ready),
        .mdv_dout     (mdv_dout),
        .mdv_sel      (mdv_sel),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_status();
        logic [7:0] s;
        s = 8'h00;
        s[0] = (q.size() != 0);
        s[2] = m_ovr;
        s[6] = FIFO && (q.size() == 4);
        return s;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (FIFO) begin
            if (q.size() == 4) m_ovr = 1'b1;
            else q.push_back(b);
        end else begin
            if (q.size() != 0) begin
                m_ovr = 1'b1;
                q.delete();
            end
            q.push_back(b);
        end
        m_latch = b;
    endfunction

    function automatic logic [7:0] model_pop();
        if (q.size() != 0) return q.pop_front();
        return FIFO ? 8'h00 : m_latch;
    endfunction

    task automatic peek(input logic [1:0] a, output logic [7:0] v);
        cpu_addr = a;
        #1;
        v = cpu_dout;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        #1;
        v = cpu_dout;
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        cpu_addr = a;
        cpu_din  = v;
        cpu_wr   = 1'b1;
        tick();
        cpu_wr   = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        mdv_dout     = b;
        mdv_rx_ready = 1'b1;
        repeat (3) tick();
        mdv_rx_ready = 1'b0;
        repeat (3) tick();
        model_push(b);
    endtask

    task automatic chk_status_rd(input string tag);
        logic [7:0] v;
        logic [7:0] e;
        e = exp_status();
        rd(2'd0, v);
        check(tag, v, e);
        m_ovr = 1'b0;
    endtask

    task automatic chk_data_rd(input string tag);
        logic [7:0] v;
        rd(2'd1, v);
        check(tag, v, model_pop());
    endtask

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        peek(2'd0, d); check("reset_status", d, 8'h00);
        check("reset_sel", mdv_sel, 8'h00);
        check("reset_irq", {7'd0, irq}, 8'h00);

        // capture latency: rise before edge T, rx_full visible after edge T+2
        mdv_dout = 8'hA5;
        mdv_rx_ready = 1'b1;
        tick(); tick();
        peek(2'd0, d); check("lat_T1_empty", d, 8'h00);
        tick();
        peek(2'd0, d); check("lat_T2_full", d, 8'h01);
        tick();
        mdv_rx_ready = 1'b0;
        repeat (3) tick();
        model_push(8'hA5);
        chk_data_rd("data_a5");
        peek(2'd0, d); check("status_after_a5", d, exp_status());

        send(8'h11);
        send(8'h22);
        chk_status_rd("two_bytes_status");
        chk_status_rd("ovr_cleared_status");
        chk_data_rd("two_bytes_data");
        chk_data_rd("drain_data");
        peek(2'd0, d); check("drained_status", d, exp_status());

`ifdef MDV_RX_FIFO_EN
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        chk_status_rd("fifo5_status");
        chk_data_rd("fifo5_d0");
        chk_data_rd("fifo5_d1");
        chk_data_rd("fifo5_d2");
        chk_data_rd("fifo5_d3");
        chk_data_rd("fifo_empty_read");
        chk_status_rd("fifo_empty_status");
`endif

        // DATA read coinciding with rx_rise
        send(8'h3C);
        mdv_dout = 8'h5A;
        mdv_rx_ready = 1'b1;
        tick(); tick();
        cpu_addr = 2'd1;
        cpu_rd = 1'b1;
        #1;
        check("simul_old_byte", cpu_dout, model_pop());
        tick();
        cpu_rd = 1'b0;
        tick();
        mdv_rx_ready = 1'b0;
        repeat (3) tick();
        model_push(8'h5A);
        peek(2'd0, d); check("simul_status", d, exp_status());
        check("simul_no_ovr", {7'd0, d[2]}, 8'h00);
        chk_data_rd("simul_new_byte");
        chk_status_rd("simul_final_status");

        // drive select shift register
        wr(2'd2, 8'h01); check("sel_w01", mdv_sel, 8'h00);
        wr(2'd2, 8'h03); check("sel_w03", mdv_sel, 8'h01);
        wr(2'd2, 8'h00); check("sel_w00", mdv_sel, 8'h01);
        wr(2'd2, 8'h02); check("sel_w02", mdv_sel, 8'h02);
        wr(2'd2, 8'h02); check("sel_w02_again", mdv_sel, 8'h02);
        peek(2'd2, d); check("ctrl_readback", d, 8'h02);
        peek(2'd3, d); check("irqclr_reads0", d, 8'h00);

        // gap interrupt
        wr(2'd2, 8'h04);
        check("sel_clk_fall_noshift", mdv_sel, 8'h02);
        mdv_gap = 1'b1;
        repeat (5) tick();
        check("gap_irq", {7'd0, irq}, 8'h01);
        peek(2'd0, d); check("gap_status", d, 8'h18);
        wr(2'd3, 8'h01);
        repeat (2) tick();
        check("gap_irq_cleared", {7'd0, irq}, 8'h00);
        peek(2'd0, d); check("gap_status_cleared", d, 8'h08);
        mdv_gap = 1'b0;
        repeat (4) tick();
        mdv_gap = 1'b1;
        tick(); tick();
        cpu_addr = 2'd3;
        cpu_din  = 8'h01;
        cpu_wr   = 1'b1;
        tick();
        cpu_wr   = 1'b0;
        repeat (3) tick();
        check("gap_set_wins", {7'd0, irq}, 8'h01);
        wr(2'd2, 8'h00);
        repeat (2) tick();
        check("irq_en_off", {7'd0, irq}, 8'h00);
        peek(2'd0, d); check("pend_kept", d, 8'h18);
        wr(2'd3, 8'h01);
        mdv_gap = 1'b0;
        repeat (4) tick();
        peek(2'd0, d); check("gap_idle_status", d, 8'h00);

        // reset while a pulse is mid-synchroniser
        mdv_dout = 8'h77;
        mdv_rx_ready = 1'b1;
        tick();
        reset_n = 1'b0;
        #2;
        check("async_sel_clear", mdv_sel, 8'h00);
        mdv_rx_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        q.delete();
        m_latch = 8'h00;
        m_ovr = 1'b0;
        repeat (4) tick();
        peek(2'd0, d); check("rst_mid_status", d, 8'h00);
        peek(2'd1, d); check("rst_mid_data", d, 8'h00);
        peek(2'd2, d); check("rst_mid_ctrl", d, 8'h00);
        check("rst_mid_irq", {7'd0, irq}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
